// File: rtl/timer_irq_pkg.sv
// ============================================================================
// timer_irq_pkg : shared types and constants for the timer interrupt aggregator
// Revision 1.0
// ============================================================================
`default_nettype none

package timer_irq_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

    localparam int                    LOST_CNT_W   = 8;
    localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/timer_irq_ctrl_prio_enc.sv
// ============================================================================
// prio_enc : lowest-index-first priority encoder, returns {found, idx}
// Revision 1.0
// ============================================================================
`default_nettype none

module prio_enc #(
    parameter int W     = 4,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning downward lets the lowest set index be the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
// ============================================================================
// timer_irq_ctrl : edge-capturing interrupt aggregator with mask, fixed-priority
//                  valid/ack presentation and saturating lost-edge counter
// Revision 1.0
// ============================================================================
`default_nettype none

module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_irq,
    input  logic                  mask_wr_en,
    input  logic [NUM_SRC-1:0]    mask_wr_data,
    output logic [NUM_SRC-1:0]    mask,
    input  logic                  pend_clr_en,
    input  logic [NUM_SRC-1:0]    pend_clr_data,
    output logic [NUM_SRC-1:0]    pending,
    output logic                  irq_valid,
    output logic [ID_W-1:0]       irq_id,
    input  logic                  irq_ack,
    output logic                  cpu_irq,
    output logic [LOST_CNT_W-1:0] lost_cnt
);

    irq_state_e              state_q;
    logic [NUM_SRC-1:0]      src_prev_q;
    logic [NUM_SRC-1:0]      pending_q, pending_d;
    logic [NUM_SRC-1:0]      mask_q;
    logic [LOST_CNT_W-1:0]   lost_q, lost_d;
    logic [ID_W-1:0]         irq_id_q;
    logic                    irq_valid_q;

    logic [NUM_SRC-1:0]      w_en_edge;
    logic [NUM_SRC-1:0]      w_lost_vec;
    logic [NUM_SRC-1:0]      w_ack_vec;
    logic [NUM_SRC-1:0]      w_clr_vec;
    logic [NUM_SRC-1:0]      w_active;
    logic [LOST_CNT_W:0]     w_lost_pop;
    logic [LOST_CNT_W:0]     w_lost_sum;
    logic                    w_found;
    logic [ID_W-1:0]         w_first_idx;

    assign w_active = pending_q & mask_q;

    prio_enc #(
        .W     (NUM_SRC),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .req_i   (w_active),
        .found_o (w_found),
        .idx_o   (w_first_idx)
    );

    always_comb begin
        w_en_edge  = src_irq & ~src_prev_q & mask_q;
        w_lost_vec = w_en_edge & pending_q;
        w_clr_vec  = pend_clr_en ? pend_clr_data : '0;
        w_ack_vec  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_vec[i] = (state_q == PRESENT) && irq_ack && (irq_id_q == ID_W'(i));
        end
        // A fresh edge wins over an ack or software clear in the same cycle.
        pending_d = w_en_edge | (pending_q & ~(w_ack_vec | w_clr_vec));
    end

    // Every lost edge counts, even several in one cycle; the clear strobe wins.
    always_comb begin
        w_lost_pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_lost_pop = w_lost_pop + (LOST_CNT_W + 1)'(w_lost_vec[i]);
        end
        w_lost_sum = {1'b0, lost_q} + w_lost_pop;
        if (pend_clr_en) begin
            lost_d = '0;
        end else if (w_lost_sum > {1'b0, LOST_CNT_MAX}) begin
            lost_d = LOST_CNT_MAX;
        end else begin
            lost_d = w_lost_sum[LOST_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            lost_q     <= '0;
        end else begin
            src_prev_q <= src_irq;
            pending_q  <= pending_d;
            lost_q     <= lost_d;
            if (mask_wr_en) begin
                mask_q <= mask_wr_data;
            end
        end
    end

    // The presented ID is frozen until ack, regardless of mask or clear activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        irq_id_q    <= w_first_idx;
                        irq_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    irq_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign mask      = mask_q;
    assign pending   = pending_q;
    assign lost_cnt  = lost_q;
    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign cpu_irq   = |w_active;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
// ============================================================================
// tb_timer_irq_ctrl : scoreboard bench for timer_irq_ctrl with reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_timer_irq_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  src_irq = '0;
    logic          mask_wr_en = 1'b0;
    logic [N-1:0]  mask_wr_data = '0;
    logic [N-1:0]  mask;
    logic          pend_clr_en = 1'b0;
    logic [N-1:0]  pend_clr_data = '0;
    logic [N-1:0]  pending;
    logic          irq_valid;
    logic [IW-1:0] irq_id;
    logic          irq_ack = 1'b0;
    logic          cpu_irq;
    logic [7:0]    lost_cnt;

    always #5 clk = ~clk;

    timer_irq_ctrl #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_irq       (src_irq),
        .mask_wr_en    (mask_wr_en),
        .mask_wr_data  (mask_wr_data),
        .mask          (mask),
        .pend_clr_en   (pend_clr_en),
        .pend_clr_data (pend_clr_data),
        .pending       (pending),
        .irq_valid     (irq_valid),
        .irq_id        (irq_id),
        .irq_ack       (irq_ack),
        .cpu_irq       (cpu_irq),
        .lost_cnt      (lost_cnt)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference state: what the interrupt block should hold after each edge.
    bit [N-1:0] m_prev, m_pend, m_mask;
    int         m_lost;
    bit         m_pres;
    int         m_id;
    int         exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_tick();
        bit [N-1:0] en, ackv, clrv, lostv;
        int         pop;
        if (rst_n !== 1'b1) begin
            m_prev = '0; m_pend = '0; m_mask = '0;
            m_lost = 0;  m_pres = 1'b0; m_id = 0;
            return;
        end
        en    = src_irq & ~m_prev & m_mask;
        ackv  = '0;
        if (m_pres && irq_ack) ackv[m_id] = 1'b1;
        clrv  = pend_clr_en ? pend_clr_data : '0;
        lostv = en & m_pend;
        pop   = $countones(lostv);
        if (m_pres) begin
            if (irq_ack) m_pres = 1'b0;
        end else if ((m_pend & m_mask) != '0) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_mask[i]) begin
                    m_id = i;
                    break;
                end
            end
            m_pres = 1'b1;
            exp_q.push_back(m_id);
        end
        m_pend = en | (m_pend & ~(ackv | clrv));
        if (pend_clr_en) m_lost = 0;
        else             m_lost = (m_lost + pop > 255) ? 255 : m_lost + pop;
        if (mask_wr_en) m_mask = mask_wr_data;
        m_prev = src_irq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        mask_wr_en  = 1'b0;
        pend_clr_en = 1'b0;
        irq_ack     = 1'b0;
    endtask

    // Monitor: state compared every cycle, presentations popped from the queue.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("pending",  {28'b0, pending}, {28'b0, m_pend});
            check("mask",     {28'b0, mask},    {28'b0, m_mask});
            check("cpu_irq",  {31'b0, cpu_irq}, {31'b0, |(m_pend & m_mask)});
            check("lost_cnt", {24'b0, lost_cnt}, m_lost);
            check("irq_valid", {31'b0, irq_valid}, {31'b0, m_pres});
            if (irq_valid === 1'b1 && !prev_v) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL present_unexpected: got id %0d expected no presentation", irq_id);
                end else begin
                    check("irq_id", {30'b0, irq_id}, exp_q.pop_front());
                end
            end else if (irq_valid === 1'b1) begin
                check("irq_id_stable", {30'b0, irq_id}, m_id);
            end
            prev_v = (irq_valid === 1'b1);
        end
    end

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_id", {30'b0, irq_id}, 0);
        rst_n = 1'b1;
        tick();

        // Single pulse on source 2
        mask_wr_en = 1'b1; mask_wr_data = 4'b1111; tick();
        src_irq = 4'b0100; tick();
        src_irq = 4'b0000;
        check("t1_pending", {28'b0, pending}, 4'b0100);
        tick();
        check("t1_valid", {31'b0, irq_valid}, 1);
        check("t1_id", {30'b0, irq_id}, 2);
        irq_ack = 1'b1; tick();
        check("t1_ack_valid", {31'b0, irq_valid}, 0);
        tick();

        // Simultaneous rises on 3 and 1
        src_irq = 4'b1010; tick();
        src_irq = 4'b0000; tick();
        check("t2_first", {30'b0, irq_id}, 1);
        irq_ack = 1'b1; tick();
        tick();
        check("t2_second", {30'b0, irq_id}, 3);
        irq_ack = 1'b1; tick();
        tick();

        // Masked source drops its edge
        mask_wr_en = 1'b1; mask_wr_data = 4'b1110; tick();
        src_irq = 4'b0001; tick();
        src_irq = 4'b0000;
        check("t3_pending", {28'b0, pending}, 0);
        check("t3_cpu_irq", {31'b0, cpu_irq}, 0);
        tick();

        // Lost-edge saturation
        mask_wr_en = 1'b1; mask_wr_data = 4'b1111; tick();
        src_irq = 4'b0001; tick();
        src_irq = 4'b0000; tick();
        for (int k = 0; k < 300; k++) begin
            src_irq = 4'b0001; tick();
            src_irq = 4'b0000; tick();
        end
        check("t4_lost_sat", {24'b0, lost_cnt}, 255);
        pend_clr_en = 1'b1; pend_clr_data = 4'b0001; tick();
        check("t4_clr_pending", {28'b0, pending}, 0);
        check("t4_clr_lost", {24'b0, lost_cnt}, 0);
        irq_ack = 1'b1; tick();
        tick();

        // New edge coincident with ack of the same source
        src_irq = 4'b0100; tick();
        src_irq = 4'b0000; tick();
        src_irq = 4'b0100; irq_ack = 1'b1; tick();
        src_irq = 4'b0000;
        check("t5_pending2", {31'b0, pending[2]}, 1);
        tick();
        check("t5_represent", {30'b0, irq_id}, 2);
        irq_ack = 1'b1; tick();
        tick();

        // Reset during presentation, source 3 held high across it
        src_irq = 4'b1010; tick();
        src_irq = 4'b1000; tick();
        check("t6_pre_pending", {28'b0, pending}, 4'b1010);
        rst_n = 1'b0; tick();
        check("t6_rst_valid", {31'b0, irq_valid}, 0);
        check("t6_rst_id", {30'b0, irq_id}, 0);
        rst_n = 1'b1; tick();
        mask_wr_en = 1'b1; mask_wr_data = 4'b1111; tick();
        for (int k = 0; k < 5; k++) tick();
        check("t6_no_irq", {31'b0, cpu_irq}, 0);
        src_irq = 4'b0000; tick();

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            src_irq = src_irq ^ N'($urandom & $urandom);
            irq_ack = (($urandom % 3) == 0);
            if (($urandom % 16) == 0) begin
                mask_wr_en = 1'b1; mask_wr_data = N'($urandom);
            end
            if (($urandom % 20) == 0) begin
                pend_clr_en = 1'b1; pend_clr_data = N'($urandom);
            end
            rst_n = (($urandom % 150) != 0);
            tick();
        end
        rst_n = 1'b1;
        src_irq = '0;
        for (int k = 0; k < 20; k++) begin
            irq_ack = 1'b1;
            tick();
        end
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
